wb_rr_bus_arbiter: RTL

WB_RR_BUS_ARBITER -- requirements
Module: wb_rr_bus_arbiter

---
 rtl/wb_rr_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wb_rr_bus_arbiter.sv
// Round-robin Wishbone bus arbiter: NM masters share one slave-side bus.
// The owner is locked for the whole m_cyc. A stalled strobe is terminated
// with a bus error after TIMEOUT cycles without ack.
//
// Handshake: a master requests with m_cyc. Once granted, each beat is
// m_stb (valid) answered by s_ack (ready/done), and the beat completes on
// the edge where both are high. m_err terminates a beat in place of m_ack.
module wb_rr_bus_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NM*AW-1:0]       m_adr,
  input  logic [NM*DW-1:0]       m_dat_w,
  input  logic [NM*(DW/8)-1:0]   m_sel,
  input  logic [NM-1:0]          m_cyc,
  input  logic [NM-1:0]          m_stb,
  input  logic [NM-1:0]          m_we,
  output logic [DW-1:0]          m_dat_r,
  output logic [NM-1:0]          m_ack,
  output logic [NM-1:0]          m_err,
  output logic [AW-1:0]          s_adr,
  output logic [DW-1:0]          s_dat_w,
  output logic [DW/8-1:0]        s_sel,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  input  logic [DW-1:0]          s_dat_r,
  input  logic                   s_ack,
  output logic [NM-1:0]          grant,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int SW = DW / 8;
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;         // current owner index
  logic [GW-1:0]   p_q, p_d;         // last owner, search starts after it
  logic [NM-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // stalled strobe cycles since grant/ack

  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;
  logic            own_cyc;
  logic            own_stb;
  logic            timeout_hit;

  assign own_cyc = m_cyc[g_q];
  assign own_stb = m_stb[g_q];

  // Error terminates the beat only while the owner still holds the cycle and
  // the slave has not acked in this same cycle (ack takes priority).
  assign timeout_hit = TO_EN && (state_q == ST_OWN) && own_cyc && !s_ack
                       && (cnt_q == CNT_MAX);

  // Round-robin search: first requester after the last owner, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NM; k++) begin
      cand = GW'((int'(p_q) + k) % NM);
      if (!pick_valid && m_cyc[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic for the ownership FSM and the timeout counter.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d           = ST_OWN;
          g_d               = pick_idx;
          p_d               = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          // Owner released the bus; the idle cycle that follows separates
          // consecutive grants.
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          cnt_d   = '0;
        end else if (s_ack) begin
          cnt_d = '0;
        end else if (own_stb && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        // Hold the bus quiet until the errored master ends its cycle.
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any grant and restarts arbitration at master 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= GW'(NM - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus steering: the slave side follows the owner only in OWN, else zeros.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    if (state_q == ST_OWN) begin
      s_adr      = m_adr[int'(g_q)*AW +: AW];
      s_dat_w    = m_dat_w[int'(g_q)*DW +: DW];
      s_sel      = m_sel[int'(g_q)*SW +: SW];
      s_cyc      = own_cyc;
      s_stb      = own_stb;
      s_we       = m_we[g_q];
      m_ack[g_q] = s_ack;
      m_err[g_q] = timeout_hit;
    end
  end

  assign m_dat_r   = s_dat_r;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
